// File: rtl/mix_col_seq.sv
// mix_col_seq: sequential AES MixColumns/InvMixColumns over one 128-bit state,
// transforming COLS_PER_CYCLE columns per RUN cycle with valid/ready on both sides.
module mix_col_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad
        $error("mix_col_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_n;
    logic [1:0]     cnt;
    logic [127:0]   work, nxt;
    logic           inv_q, last;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // k is the circulant offset (j-i) mod 4 into the row-0 coefficients
    function automatic logic [7:0] cm(input logic [7:0] b, input logic [1:0] k, input logic inv);
        logic [7:0] b2, b4, b8;
        b2 = xt(b);
        b4 = xt(b2);
        b8 = xt(b4);
        if (inv)
            return k == 2'd0 ? b8 ^ b4 ^ b2 : k == 2'd1 ? b8 ^ b2 ^ b : k == 2'd2 ? b8 ^ b4 ^ b : b8 ^ b;
        return k == 2'd0 ? b2 : k == 2'd1 ? b2 ^ b : b;
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] col, input logic inv);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                y[31-8*i -: 8] = y[31-8*i -: 8] ^ cm(col[31-8*j -: 8], 2'(j - i), inv);
        return y;
    endfunction

    // cnt is always a multiple of COLS_PER_CYCLE, so cnt+k never passes column 3
    always_comb begin
        nxt = work;
        for (int k = 0; k < COLS_PER_CYCLE; k++)
            nxt[127-32*(int'(cnt)+k) -: 32] = mix(work[127-32*(int'(cnt)+k) -: 32], inv_q);
    end

    assign last      = (3'(cnt) + 3'(COLS_PER_CYCLE)) == 3'd4;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign out_data  = work;

    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (in_valid ? RUN : IDLE)
                : state == RUN  ? (last ? DONE : RUN)
                : (out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            work  <= '0;
            inv_q <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && in_valid) begin
                work  <= in_data;
                inv_q <= in_inv;
                cnt   <= '0;
            end else if (state == RUN) begin
                work <= nxt;
                cnt  <= cnt + 2'(COLS_PER_CYCLE);
            end
        end
    end
endmodule
